// File: rtl/seq_binary_to_bcd.sv
// Sequential binary-to-BCD converter (double dabble), one operand bit per clock.
// Ports: clk, rst (async, active-high), start/bin in; busy, done, bcd, ovf out.
module seq_binary_to_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state;
    state_t          state_nx;

    logic [WIDTH-1:0] opnd;
    logic [BW-1:0]    work;
    logic [BW-1:0]    adj;
    logic [BW-1:0]    work_nx;
    logic [CW-1:0]    cnt;
    logic             sticky;
    logic             carry;
    logic             load;
    logic             step;
    logic             fin;

    // Per-digit add-3 correction; digits never carry into each other.
    always_comb begin
        adj = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end
        end
    end

    // Bit leaving the top digit means the value no longer fits.
    always_comb begin
        work_nx = {adj[BW-2:0], opnd[WIDTH-1]};
        carry   = adj[BW-1];
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        fin      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == CW'(1)) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd   <= '0;
            work   <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            done   <= 1'b0;
            bcd    <= '0;
            ovf    <= 1'b0;
        end else begin
            done <= fin;
            if (load) begin
                opnd   <= bin;
                work   <= '0;
                sticky <= 1'b0;
                cnt    <= CW'(WIDTH);
            end else if (step) begin
                opnd   <= opnd << 1;
                work   <= work_nx;
                sticky <= sticky | carry;
                cnt    <= cnt - CW'(1);
                if (fin) begin
                    bcd <= work_nx;
                    ovf <= sticky | carry;
                end
            end
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// Self-checking bench for seq_binary_to_bcd, 8-bit/3-digit and 16-bit/4-digit.
// Reference results come from decimal arithmetic on the operand.
module tb_seq_binary_to_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0;
    logic [7:0]  bin8 = '0;
    logic        busy8, done8, ovf8;
    logic [11:0] bcd8;

    logic        start16 = 1'b0;
    logic [15:0] bin16 = '0;
    logic        busy16, done16, ovf16;
    logic [15:0] bcd16;

    int checks = 0;
    int errors = 0;

    logic        sel = 1'b0;
    logic        cur_done;
    logic        cur_busy;
    logic        cur_ovf;
    logic [15:0] cur_bcd;

    assign cur_done = sel ? done16 : done8;
    assign cur_busy = sel ? busy16 : busy8;
    assign cur_ovf  = sel ? ovf16  : ovf8;
    assign cur_bcd  = sel ? bcd16  : {4'h0, bcd8};

    always #5 clk = ~clk;

    seq_binary_to_bcd #(.WIDTH(8), .DIGITS(3)) u8 (
        .clk(clk), .rst(rst), .start(start8), .bin(bin8),
        .busy(busy8), .done(done8), .bcd(bcd8), .ovf(ovf8)
    );

    seq_binary_to_bcd #(.WIDTH(16), .DIGITS(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .bin(bin16),
        .busy(busy16), .done(done16), .bcd(bcd16), .ovf(ovf16)
    );

    // Decimal digits of v, lowest first; keeping d digits gives v mod 10^d.
    function automatic logic [15:0] bcd_of(int v, int d);
        logic [15:0] r;
        int m;
        r = '0;
        m = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic conv(input bit s, input int v);
        int n;
        int d;
        int w;
        int lim;
        sel = s;
        d   = s ? 4 : 3;
        w   = s ? 16 : 8;
        lim = s ? 10000 : 1000;
        @(negedge clk);
        if (s) begin start16 = 1'b1; bin16 = 16'(v); end
        else   begin start8  = 1'b1; bin8  = 8'(v);  end
        @(negedge clk);
        if (s) begin start16 = 1'b0; bin16 = 16'($urandom); end
        else   begin start8  = 1'b0; bin8  = 8'($urandom);  end
        chk("busy_after_accept", 32'(cur_busy), 32'd1);
        n = 0;
        while (!cur_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, w);
        chk("bcd", 32'(cur_bcd), 32'(bcd_of(v, d)));
        chk("ovf", 32'(cur_ovf), 32'(v >= lim));
        chk("busy_at_done", 32'(cur_busy), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(cur_done), 32'd0);
    endtask

    initial begin
        int n;
        int cnt;
        logic [15:0] seen;

        #12;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_bcd", 32'(bcd8), 32'd0);
        chk("rst_ovf", 32'(ovf8), 32'd0);
        chk("rst_bcd16", 32'(bcd16), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        conv(1'b0, 0);

        // Back-to-back with start held: 173 then 255.
        sel = 1'b0;
        @(negedge clk);
        start8 = 1'b1;
        bin8   = 8'd173;
        @(negedge clk);
        bin8 = 8'd255;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            chk("b2b_done", 32'(done8), 32'(c == 8 || c == 17));
            chk("b2b_busy", 32'(busy8), 32'(!(c == 8 || c == 17)));
            if (c == 8)  chk("b2b_bcd0", 32'(bcd8), 32'h173);
            if (c == 17) chk("b2b_bcd1", 32'(bcd8), 32'h255);
        end
        start8 = 1'b0;
        @(negedge clk);
        chk("b2b_stop", 32'(busy8), 32'd0);

        // Start while busy is ignored.
        @(negedge clk);
        start8 = 1'b1;
        bin8   = 8'd42;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        start8 = 1'b1;
        bin8   = 8'd99;
        @(negedge clk);
        start8 = 1'b0;
        cnt  = 0;
        seen = '0;
        for (int c = 0; c < 25; c++) begin
            if (done8) begin
                cnt++;
                seen = {4'h0, bcd8};
            end
            @(negedge clk);
        end
        chk("ign_count", cnt, 1);
        chk("ign_bcd", 32'(seen), 32'h042);

        // Reset mid-conversion.
        @(negedge clk);
        start8 = 1'b1;
        bin8   = 8'd85;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy8), 32'd0);
        chk("mid_rst_done", 32'(done8), 32'd0);
        chk("mid_rst_bcd", 32'(bcd8), 32'd0);
        chk("mid_rst_ovf", 32'(ovf8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done8) cnt++;
        end
        chk("mid_rst_nodone", cnt, 0);
        conv(1'b0, 9);

        // Wide instance corners.
        conv(1'b1, 9999);
        conv(1'b1, 65535);
        conv(1'b1, 10000);
        conv(1'b1, 0);
        for (int k = 0; k < 12; k++) begin
            conv(1'b1, int'($urandom_range(0, 65535)));
        end

        // Exhaustive 8-bit, back-to-back.
        sel = 1'b0;
        @(negedge clk);
        start8 = 1'b1;
        bin8   = 8'd0;
        for (int v = 0; v < 256; v++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done8 && n < 20);
            chk("exh_lat", n, (v == 0) ? 9 : 9);
            chk("exh_bcd", 32'(bcd8), 32'(bcd_of(v, 3)));
            chk("exh_ovf", 32'(ovf8), 32'd0);
            if (v < 255) bin8 = 8'(v + 1);
            else         start8 = 1'b0;
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
